// File: rtl/riscv_muldiv_seq_pkg.sv
// Shared op encodings, FSM states and op-decode helpers for the sequential
// RV32M multiply/divide unit.
package riscv_muldiv_seq_pkg;

  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_DIV    = 4'd4,
    OP_DIVU   = 4'd5,
    OP_REM    = 4'd6,
    OP_REMU   = 4'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  // Codes 8-15 fall through to plain MUL, so only 4-7 are divides.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op[3:2] == 2'b01);
  endfunction

  function automatic logic is_mul_low(input logic [3:0] op);
    return (op == OP_MUL) || op[3];
  endfunction

  function automatic logic op_a_signed(input logic [3:0] op);
    return !((op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU));
  endfunction

  function automatic logic op_b_signed(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) ||
           (op == OP_REM) || op[3];
  endfunction

endpackage

// File: rtl/riscv_multiplier.sv
// Single-cycle 32x32 multiplier with per-operand signedness; returns the
// full 64-bit product. Never stalls, so its stall output is tied low.
module riscv_multiplier (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        a_signed_i,
  input  logic        b_signed_i,
  output logic [63:0] product_o,
  output logic        ex_stall_o
);

  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;

  // Extend each operand by one bit so one signed multiply covers all mixes.
  always_comb begin
    a_ext     = {a_signed_i & a_i[31], a_i};
    b_ext     = {b_signed_i & b_i[31], b_i};
    product_o = 64'(64'(a_ext) * 64'(b_ext));
    ex_stall_o = 1'b0;
  end

endmodule

// File: rtl/riscv_muldiv_seq.sv
// Sequential RV32M multiply/divide unit: 2-cycle multiply, 33-cycle
// restoring divide, 1-cycle divide-by-zero and signed-overflow results.
module riscv_muldiv_seq
  import riscv_muldiv_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] ra_i,
  input  logic [31:0] rb_i,
  input  logic        flush_i,
  output logic        ex_stall_o,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  state_e      state_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        a_signed_q;
  logic        b_signed_q;
  logic [63:0] product_w;
  logic [63:0] product_q;
  logic        ex_stall_mul_w;
  logic        unused_ok;
  logic [4:0]  count_q;
  logic [31:0] quot_q;
  logic [31:0] rem_q;
  logic [31:0] divisor_q;
  logic        neg_quot_q;
  logic        neg_rem_q;

  logic        in_a_signed;
  logic        in_b_signed;
  logic        in_div_zero;
  logic        in_div_ovf;
  logic [31:0] in_a_mag;
  logic [31:0] in_b_mag;
  logic [31:0] in_special;

  logic [32:0] div_shift_w;
  logic [32:0] div_diff_w;
  logic [31:0] quot_next_w;
  logic [31:0] rem_next_w;
  logic [31:0] div_result_w;
  logic [31:0] mul_result_w;

  riscv_multiplier u_multiplier (
    .a_i        (a_q),
    .b_i        (b_q),
    .a_signed_i (a_signed_q),
    .b_signed_i (b_signed_q),
    .product_o  (product_w),
    .ex_stall_o (ex_stall_mul_w)
  );

  // The multiplier never stalls; its product is captured in MUL but only read here.
  assign unused_ok = ex_stall_mul_w ^ (^product_q);

  assign ready_o    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign ex_stall_o = (ready_o & start_i & ~flush_i) ||
                      (state_q == ST_MUL) || (state_q == ST_DIV);

  // Decode the incoming request: magnitudes and the two one-cycle divide cases.
  always_comb begin
    in_a_signed = op_a_signed(op_i);
    in_b_signed = op_b_signed(op_i);
    in_a_mag    = (in_a_signed && ra_i[31]) ? -ra_i : ra_i;
    in_b_mag    = (in_b_signed && rb_i[31]) ? -rb_i : rb_i;
    in_div_zero = (rb_i == '0);
    in_div_ovf  = in_a_signed && (ra_i == 32'h8000_0000) && (rb_i == '1);
    if (in_div_zero) in_special = op_i[1] ? ra_i : '1;
    else             in_special = op_i[1] ? '0 : 32'h8000_0000;
  end

  // One restoring-division step plus the sign fix-up applied on the last step.
  always_comb begin
    div_shift_w = {rem_q, quot_q[31]};
    div_diff_w  = div_shift_w - {1'b0, divisor_q};
    rem_next_w  = div_diff_w[32] ? div_shift_w[31:0] : div_diff_w[31:0];
    quot_next_w = {quot_q[30:0], ~div_diff_w[32]};
    if (op_q[1]) div_result_w = neg_rem_q  ? -rem_next_w  : rem_next_w;
    else         div_result_w = neg_quot_q ? -quot_next_w : quot_next_w;
    mul_result_w = is_mul_low(op_q) ? product_w[31:0] : product_w[63:32];
  end

  // Control FSM with registered operands, divider state and result.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      a_signed_q <= 1'b0;
      b_signed_q <= 1'b0;
      product_q  <= '0;
      count_q    <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_o   <= '0;
      done_o     <= 1'b0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      done_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            op_q       <= op_i;
            a_q        <= ra_i;
            b_q        <= rb_i;
            a_signed_q <= in_a_signed;
            b_signed_q <= in_b_signed;
            if (!is_div_op(op_i)) begin
              state_q <= ST_MUL;
            end else if (in_div_zero || in_div_ovf) begin
              result_o <= in_special;
              done_o   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              quot_q     <= in_a_mag;
              rem_q      <= '0;
              divisor_q  <= in_b_mag;
              count_q    <= '0;
              neg_quot_q <= in_a_signed && (ra_i[31] ^ rb_i[31]);
              neg_rem_q  <= in_a_signed && ra_i[31];
              state_q    <= ST_DIV;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_MUL: begin
          product_q <= product_w;
          result_o  <= mul_result_w;
          done_o    <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DIV: begin
          quot_q  <= quot_next_w;
          rem_q   <= rem_next_w;
          count_q <= count_q + 5'd1;
          done_o  <= 1'b0;
          if (count_q == 5'd31) begin
            result_o <= div_result_w;
            done_o   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_seq.sv
// Self-checking bench for riscv_muldiv_seq: directed cases with literal
// expectations plus randomized traffic checked every cycle against an
// arithmetic transaction model.
module tb_riscv_muldiv_seq;

  localparam logic [3:0] T_MUL = 4'd0, T_MULH = 4'd1, T_MULHSU = 4'd2, T_MULHU = 4'd3;
  localparam logic [3:0] T_DIV = 4'd4, T_DIVU = 4'd5, T_REM = 4'd6, T_REMU = 4'd7;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [3:0]  op;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        ex_stall;
  logic        ready;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transaction model state
  bit          m_pending = 0;
  int          m_done_cyc = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_last = '0;

  riscv_muldiv_seq dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .start_i    (start),
    .op_i       (op),
    .ra_i       (ra),
    .rb_i       (rb),
    .flush_i    (flush),
    .ex_stall_o (ex_stall),
    .ready_o    (ready),
    .done_o     (done),
    .result_o   (result)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    case (o)
      T_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      T_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      T_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      T_DIV, T_REM: begin
        if (b == 0) return (o == T_REM) ? a : 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return (o == T_REM) ? 32'h0 : 32'h8000_0000;
        p = (o == T_REM) ? 64'(sa % sb) : 64'(sa / sb);
        return p[31:0];
      end
      T_DIVU, T_REMU: begin
        if (b == 0) return (o == T_REMU) ? a : 32'hFFFF_FFFF;
        p = (o == T_REMU) ? 64'(ua % ub) : 64'(ua / ub);
        return p[31:0];
      end
      default:  begin p = 64'(ua * ub); return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (o > 4'd7 || o < 4'd4) return 2;
    if (b == 0) return 1;
    if ((o == T_DIV || o == T_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Per-cycle compare of every output against the transaction model.
  always @(negedge clk) begin
    bit exp_done;
    bit exp_ready;
    bit exp_stall;
    logic [31:0] exp_res;
    if (rst) begin
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_stall", {31'd0, ex_stall}, {31'd0, start & ~flush});
      m_pending = 0;
      m_last = '0;
    end else begin
      exp_done  = m_pending && (cyc == m_done_cyc);
      exp_ready = !m_pending || exp_done;
      exp_res   = exp_done ? m_res : m_last;
      exp_stall = (exp_ready && start && !flush) || (m_pending && !exp_done);
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("ready", {31'd0, ready}, {31'd0, exp_ready});
      chk("stall", {31'd0, ex_stall}, {31'd0, exp_stall});
      chk("result", result, exp_res);
      if (exp_done) begin
        m_last = m_res;
        m_pending = 0;
      end
      if (flush) begin
        m_pending = 0;
      end else if (exp_ready && start) begin
        m_pending  = 1;
        m_done_cyc = cyc + ref_latency(op, ra, rb);
        m_res      = ref_result(op, ra, rb);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done_o after an accept in cycle t0, then checks value and latency.
  task automatic wait_done(input string nm, input int t0, input logic [31:0] er, input int el);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_result"}, result, er);
      chk({nm, "_latency"}, 32'(cyc - t0), 32'(el));
    end
    step();
  endtask

  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input int el);
    int t0;
    op = o; ra = a; rb = b; start = 1; t0 = cyc;
    step();
    start = 0;
    wait_done(nm, t0, er, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit saw;
    rst = 1; start = 0; flush = 0; op = '0; ra = '0; rb = '0;

    chk("pin_model_mul", ref_result(T_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_model_mulhsu", ref_result(T_MULHSU, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("pin_model_rem", ref_result(T_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_model_lat_div", 32'(ref_latency(T_DIVU, 32'd100, 32'd7)), 32'd33);

    repeat (3) step();
    rst = 0;
    step();

    run_op("mul", T_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run_op("mulh", T_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_op("mulhu", T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("mulhsu", T_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2);
    run_op("div", T_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem", T_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu", T_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", T_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_by0", T_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_by0", T_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", T_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("op9_as_mul", 4'd9, 32'd3, 32'd5, 32'd15, 2);

    // Flush mid-divide: no done, result held, new MUL accepted right after.
    op = T_DIVU; ra = 32'd1000; rb = 32'd3; start = 1; t0 = cyc;
    step();
    start = 0; saw = 0;
    repeat (9) begin
      if (done) saw = 1;
      step();
    end
    flush = 1;
    if (done) saw = 1;
    step();
    flush = 0;
    chk("flush_no_done", {31'd0, saw | done}, 32'd0);
    chk("flush_ready", {31'd0, ready}, 32'd1);
    chk("flush_result_held", result, 32'd15);
    chk("flush_cycle", 32'(cyc - t0), 32'd11);
    run_op("mul_after_flush", T_MUL, 32'd6, 32'd7, 32'd42, 2);

    // Asynchronous reset mid-divide, then MUL and a back-to-back DIV.
    op = T_DIV; ra = 32'd1000; rb = 32'd7; start = 1;
    step();
    start = 0;
    repeat (5) step();
    rst = 1;
    #1;
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_ready", {31'd0, ready}, 32'd1);
    chk("async_rst_stall", {31'd0, ex_stall}, 32'd0);
    step();
    step();
    rst = 0;
    op = T_MULHU; ra = 32'h0001_0000; rb = 32'h0001_0000; start = 1; t0 = cyc;
    step();
    start = 0;
    step();
    chk("rst_mul_done", {31'd0, done}, 32'd1);
    chk("rst_mul_result", result, 32'd1);
    chk("rst_mul_latency", 32'(cyc - t0), 32'd2);
    op = T_DIVU; ra = 32'd1000; rb = 32'd10; start = 1; t0 = cyc;
    step();
    start = 0;
    wait_done("b2b_div", t0, 32'd100, 33);

    // Randomized traffic, including starts while busy and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 39) == 0);
      op = 4'($urandom_range(0, 15));
      ra = pick();
      rb = pick();
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      step();
    end
    start = 0;
    flush = 0;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv_seq.md
RISCV_MULDIV_SEQ -- requirements
Module: riscv_muldiv_seq

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 reset_i  in  1  asynchronous, active-high reset.
REQ-003 start_i  in  1  request valid from EX stage; sampled only when the block is ready.
REQ-004 op_i  in  4  operation code; encodings defined in the shared defines.
REQ-005 ra_i  in  32  operand A, or dividend.
REQ-006 rb_i  in  32  operand B, or divisor.
REQ-007 flush_i  in  1  pipeline flush; aborts any operation in flight.
REQ-008 ex_stall_o  out  1  pipeline stall request.
REQ-009 ready_o  out  1  block accepts start_i this cycle.
REQ-010 done_o  out  1  one-cycle pulse; result_o valid.
REQ-011 result_o  out  32  operation result; holds its value until the next done_o.

Function
REQ-012 Ops SHALL be: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7; codes 8-15 are treated as MUL.
REQ-013 FSM states SHALL be IDLE, MUL, DIV, DONE; ready_o=1 in IDLE and DONE only.
REQ-014 Transitions: IDLE/DONE + start_i + mul op -> MUL; IDLE/DONE + start_i + div op (normal) -> DIV; IDLE/DONE + start_i + div special case -> DONE; IDLE/DONE without start_i -> IDLE; MUL -> DONE; DIV with counter=31 -> DONE.
REQ-015 On acceptance, operands, op and signedness SHALL be registered: a_signed for MUL/MULH/MULHSU/DIV/REM; b_signed for MUL/MULH/DIV/REM.
REQ-016 The multiply SHALL use the registered operands; the 64-bit product is registered in state MUL.
REQ-017 Multiply output: MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32].
REQ-018 Multiply latency SHALL be 2: accept at edge N, done_o high in cycle N+2.
REQ-019 Divide SHALL be 32-iteration restoring division on operand magnitudes, one quotient bit per cycle, with a 5-bit counter.
REQ-020 Normal divide latency SHALL be 33: done_o high 33 cycles after the accept edge.
REQ-021 Signed divide: quotient is negated when operand signs differ; remainder takes the sign of the dividend.
REQ-022 Divisor=0 SHALL give quotient 0xFFFFFFFF and remainder = dividend, with latency 1.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0, with latency 1.
REQ-024 ex_stall_o = (ready_o & start_i) | state==MUL | state==DIV, combinational.
REQ-025 done_o is high only in DONE; result_o is registered on entry to DONE.
REQ-026 A start_i in DONE SHALL be accepted (back-to-back); done_o still pulses for the finishing op.
REQ-027 flush_i SHALL force IDLE on the next edge from any state, with no done_o for the aborted op.
REQ-028 flush_i has priority over start_i in the same cycle; start_i is ignored and ex_stall_o is deasserted.
REQ-029 result_o is not altered by a flush.

Reset
REQ-030 reset_i SHALL drive state=IDLE, counter=0, all operand/product/quotient/remainder registers=0, result_o=0, done_o=0.
REQ-031 After reset: ex_stall_o=0 and ready_o=1.
REQ-032 Reset mid-operation SHALL discard the operation with no done_o; the first accept is legal on the first edge after release.

Structure
REQ-033 Op encodings and FSM state constants SHALL reside in riscv_defines.v.
REQ-034 The product SHALL come from one instance of riscv_multiplier, with ex_stall_mul_w unused.
REQ-035 The divider datapath SHALL be inline; there is no further sub-module.

Verification
REQ-036 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; done_o at cycle +2; ex_stall_o high for cycles +0..+1.
REQ-037 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-038 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM gives 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU gives 2; done_o at +33.
REQ-039 DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM gives 0; done_o at +1.
REQ-040 DIVU started, flush_i at cycle +10 -> IDLE at +11, no done_o, result_o unchanged; a new MUL accepted at +11 completes normally.
REQ-041 reset_i asserted mid-DIV -> all outputs 0 immediately; a MUL issued right after release -> done_o at +2; a DIV start in DONE cycle -> accepted, done_o at +33.
